// File: rtl/bkm_residual_iter_if.sv
// Bus between the BKM residual iterator and its stager / get_d neighbours.
// Optional digit-log outputs exist only with BKM_ITER_DIGIT_LOG_EN.
interface bkm_residual_iter_if #(
  parameter int W      = 8,
  parameter int N_ITER = 8,
  parameter int ITER_W = 4
);
  logic                start;
  logic                mode;
  logic signed [W-1:0] u0;
  logic signed [W-1:0] v0;
  logic signed [W-1:0] u;
  logic signed [W-1:0] v;
  logic                mode_o;
  logic [1:0]          d_x;
  logic [1:0]          d_y;
  logic                busy;
  logic                done;
  logic [ITER_W-1:0]   iter;
  logic                ovf;
  logic                dig_err;
`ifdef BKM_ITER_DIGIT_LOG_EN
  logic [2*N_ITER-1:0] dlog_x;
  logic [2*N_ITER-1:0] dlog_y;
`endif

  modport slave (
    input  start, mode, u0, v0, d_x, d_y,
`ifdef BKM_ITER_DIGIT_LOG_EN
    output dlog_x, dlog_y,
`endif
    output u, v, mode_o, busy, done, iter, ovf, dig_err
  );

  modport master (
    output start, mode, u0, v0, d_x, d_y,
`ifdef BKM_ITER_DIGIT_LOG_EN
    input  dlog_x, dlog_y,
`endif
    input  u, v, mode_o, busy, done, iter, ovf, dig_err
  );
endinterface

// File: rtl/bkm_residual_iter.sv
// BKM residual iterator: one shift-and-add update per clock, done N_ITER+1 cycles after start; no backpressure, start ignored unless IDLE.
// Optional macro BKM_ITER_DIGIT_LOG_EN adds per-run digit logs dlog_x/dlog_y.
module bkm_residual_iter #(
  parameter int W      = 8,
  parameter int N_ITER = 8,
  parameter int ITER_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bkm_residual_iter_if.slave   bus
);
  localparam int EW = 2*W + 2;
  localparam int LW = 2*N_ITER;
  localparam logic signed [EW-1:0] ONE = {{(EW-1){1'b0}}, 1'b1} << (W-3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] u_q, u_d, v_q, v_d;
  logic                mode_q, mode_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic signed [EW-1:0] u_x, v_x, sh_u, sh_v, u_nxt, v_nxt;
  logic                 dx_bad, dy_bad;

  // Illegal code 2'b10 falls into the default arm and contributes nothing.
  function automatic logic signed [EW-1:0] dmul(input logic [1:0] d,
                                                input logic signed [EW-1:0] x);
    case (d)
      2'b01:   return x;
      2'b11:   return -x;
      default: return '0;
    endcase
  endfunction

  function automatic logic fits(input logic signed [EW-1:0] x);
    return (x[EW-1:W-1] == '0) || (x[EW-1:W-1] == '1);
  endfunction

  always_comb begin
    u_x    = {{(EW-W){u_q[W-1]}}, u_q};
    v_x    = {{(EW-W){v_q[W-1]}}, v_q};
    dx_bad = (bus.d_x == 2'b10);
    dy_bad = (bus.d_y == 2'b10);
    sh_u   = (dmul(bus.d_x, u_x) - dmul(bus.d_y, v_x)) >>> iter_q;
    sh_v   = (dmul(bus.d_x, v_x) + dmul(bus.d_y, u_x)) >>> iter_q;
    u_nxt  = (u_x <<< 1) - dmul(bus.d_x, ONE) + sh_u;
    v_nxt  = (v_x <<< 1) - dmul(bus.d_y, ONE) + sh_v;
  end

`ifdef BKM_ITER_DIGIT_LOG_EN
  logic [LW-1:0] dlog_x_q, dlog_x_d, dlog_y_q, dlog_y_d;
`endif

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    mode_d  = mode_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef BKM_ITER_DIGIT_LOG_EN
    dlog_x_d = dlog_x_q;
    dlog_y_d = dlog_y_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          u_d     = bus.u0;
          v_d     = bus.v0;
          mode_d  = bus.mode;
          iter_d  = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
`ifdef BKM_ITER_DIGIT_LOG_EN
          dlog_x_d = '0;
          dlog_y_d = '0;
`endif
        end
      end
      RUN: begin
        u_d    = u_nxt[W-1:0];
        v_d    = v_nxt[W-1:0];
        iter_d = iter_q + 1'b1;
        ovf_d  = ovf_q | ~fits(u_nxt) | ~fits(v_nxt);
        err_d  = err_q | dx_bad | dy_bad;
`ifdef BKM_ITER_DIGIT_LOG_EN
        dlog_x_d = (dlog_x_q << 2) | LW'(bus.d_x);
        dlog_y_d = (dlog_y_q << 2) | LW'(bus.d_y);
`endif
        if (iter_q == ITER_W'(N_ITER-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      mode_q  <= 1'b0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

`ifdef BKM_ITER_DIGIT_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlog_x_q <= '0;
      dlog_y_q <= '0;
    end else begin
      dlog_x_q <= dlog_x_d;
      dlog_y_q <= dlog_y_d;
    end
  end

  assign bus.dlog_x = dlog_x_q;
  assign bus.dlog_y = dlog_y_q;
`endif

  assign bus.u       = u_q;
  assign bus.v       = v_q;
  assign bus.mode_o  = mode_q;
  assign bus.iter    = iter_q;
  assign bus.ovf     = ovf_q;
  assign bus.dig_err = err_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_bkm_residual_iter.sv
// Scoreboard bench for bkm_residual_iter: stimulus queues expected finals, a negedge monitor checks them on done.
module tb_bkm_residual_iter;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int IW = 4;
  localparam int T  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(T/2) clk = ~clk;

  bkm_residual_iter_if #(.W(W), .N_ITER(N), .ITER_W(IW)) bus ();

  bkm_residual_iter #(.W(W), .N_ITER(N), .ITER_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          u, v, ovf, err, iter, edges, mode;
    logic [15:0] dlx, dly;
  } exp_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];
  int   snap_u[$];
  int   snap_v[$];
  logic [1:0] dxt[16];
  logic [1:0] dyt[16];
  logic [15:0] cur_xs, cur_ys;
  longint start_t = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Digits packed first-in-MSB, the same layout as the digit logs.
  task automatic set_digits(input logic [15:0] xs, input logic [15:0] ys);
    for (int n = 0; n < 16; n++) begin
      dxt[n] = 2'b00;
      dyt[n] = 2'b00;
    end
    for (int n = 0; n < N; n++) begin
      dxt[n] = xs[15-2*n -: 2];
      dyt[n] = ys[15-2*n -: 2];
    end
    cur_xs = xs;
    cur_ys = ys;
  endtask

  function automatic int dig(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int wrap8(input int x);
    logic [7:0] t;
    t = x[7:0];
    return int'($signed(t));
  endfunction

  function automatic exp_t model(input int u0, input int v0, input int m);
    exp_t e;
    int u, v, a, b, nu, nv, dx, dy;
    u = u0; v = v0;
    e.ovf = 0; e.err = 0;
    for (int n = 0; n < N; n++) begin
      dx = dig(dxt[n]);
      dy = dig(dyt[n]);
      if (dxt[n] == 2'b10 || dyt[n] == 2'b10) e.err = 1;
      a  = dx*u - dy*v;
      b  = dx*v + dy*u;
      nu = 2*u - dx*32 + (a >>> n);
      nv = 2*v - dy*32 + (b >>> n);
      if (nu < -128 || nu > 127 || nv < -128 || nv > 127) e.ovf = 1;
      u = wrap8(nu);
      v = wrap8(nv);
    end
    e.u = u; e.v = v; e.iter = N; e.edges = N + 1; e.mode = m;
    e.dlx = cur_xs; e.dly = cur_ys;
    return e;
  endfunction

  function automatic exp_t hand(input int u, input int v, input int ovf, input int err, input int m);
    exp_t e;
    e.u = u; e.v = v; e.ovf = ovf; e.err = err; e.iter = N; e.edges = N + 1; e.mode = m;
    e.dlx = cur_xs; e.dly = cur_ys;
    return e;
  endfunction

  always @(negedge clk) begin
    bus.d_x = dxt[bus.iter];
    bus.d_y = dyt[bus.iter];
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.iter == 4'd1 && snap_u.size() > 0) begin
        chk("step1_u", longint'($signed(bus.u)), longint'(snap_u.pop_front()));
        chk("step1_v", longint'($signed(bus.v)), longint'(snap_v.pop_front()));
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("final_u", longint'($signed(bus.u)), longint'(e.u));
          chk("final_v", longint'($signed(bus.v)), longint'(e.v));
          chk("ovf", longint'(bus.ovf), longint'(e.ovf));
          chk("dig_err", longint'(bus.dig_err), longint'(e.err));
          chk("final_iter", longint'(bus.iter), longint'(e.iter));
          chk("mode_o", longint'(bus.mode_o), longint'(e.mode));
          chk("busy_cycles", longint'(busy_cnt), longint'(N));
          chk("done_edge", (longint'($time) - start_t - T/2) / T + 1, longint'(e.edges));
`ifdef BKM_ITER_DIGIT_LOG_EN
          chk("dlog_x", longint'(bus.dlog_x), longint'(e.dlx));
          chk("dlog_y", longint'(bus.dlog_y), longint'(e.dly));
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic do_start(input int a, input int b, input logic m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.u0    = W'(a);
    bus.v0    = W'(b);
    bus.mode  = m;
    @(posedge clk);
    start_t = longint'($time);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input logic trailing);
    int k;
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("done_timeout", 0, 1);
    if (trailing) @(negedge clk);
  endtask

  initial begin
    #(100000*T);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.u0    = '0;
    bus.v0    = '0;
    set_digits(16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rst_u", longint'(bus.u), 0);
    chk("rst_v", longint'(bus.v), 0);
    chk("rst_iter", longint'(bus.iter), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_dig_err", longint'(bus.dig_err), 0);
    chk("rst_mode_o", longint'(bus.mode_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero digits: 16 -> 32 -> 64 -> -128 (wrap) -> 0 ... with ovf.
    set_digits(16'h0000, 16'h0000);
    sb.push_back(hand(0, 0, 1, 0, 1));
    do_start(16, 0, 1'b1);
    wait_done(1'b1);

    // Single step with d_x=1 at n=0: u'=64, v'=0; later zero digits wrap u to 0.
    set_digits(16'h4000, 16'h0000);
    snap_u.push_back(64); snap_v.push_back(0);
    sb.push_back(hand(0, 0, 1, 0, 0));
    do_start(32, 0, 1'b0);
    wait_done(1'b1);

    // Single step with d_y=1 at n=0: u'=64, v'=0-32+32=0.
    set_digits(16'h0000, 16'h4000);
    snap_u.push_back(64); snap_v.push_back(0);
    sb.push_back(hand(0, 0, 1, 0, 0));
    do_start(32, 0, 1'b0);
    wait_done(1'b1);

    // Handshake: start re-pulsed during RUN and DONE must be ignored.
    set_digits(16'h7134, 16'h170D);
    sb.push_back(model(20, -12, 1));
    do_start(20, -12, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.u0 = W'(99); bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1'b0);
    bus.start = 1'b1; bus.u0 = W'(-50);
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_after_done_start", longint'(bus.busy), 0);
    repeat (12) @(negedge clk);

    // Illegal digit at n=2, then the same run with 0 there; dig_err clears.
    set_digits(16'h4B41, 16'hD070);
    sb.push_back(model(-24, 10, 0));
    do_start(-24, 10, 1'b0);
    wait_done(1'b1);
    set_digits(16'h4341, 16'hD070);
    sb.push_back(model(-24, 10, 0));
    do_start(-24, 10, 1'b0);
    chk("dig_err_cleared", longint'(bus.dig_err), 0);
    wait_done(1'b1);

    // Reset mid-run at iter 3: abort to reset values, no done pulse.
    set_digits(16'h0000, 16'h0000);
    do_start(16, 0, 1'b1);
    k = 0;
    while (bus.iter != 4'd3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("iter3_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_u", longint'(bus.u), 0);
    chk("abort_v", longint'(bus.v), 0);
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_iter", longint'(bus.iter), 0);
    chk("abort_done", longint'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Digit log vector: 1,0,-1,1,0,0,1,-1 -> 16'b01_00_11_01_00_00_01_11.
    set_digits(16'b01_00_11_01_00_00_01_11, 16'h0000);
    sb.push_back(model(8, 4, 0));
    do_start(8, 4, 1'b0);
    wait_done(1'b1);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
